uart_word_loader: RTL
=====================

# uart_word_loader

Serial front end for the 16-bit pipelined CPU's program/data load path. It receives 8N1 UART bytes on a single RX line and assembles 3-byte packets (target header, data high, data low). Each complete packet is presented as a one-cycle `uart_en` pulse with `uart_sel`/`uart_data`, directly feeding the datapath's UART instruction-load and memory-load ports.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit; must be ≥ 8 and even.
- `TIMEOUT_BITS`, default 32: mid-packet idle limit, in bit periods.

Ports:
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rx`  in  1  raw serial line, idle high, asynchronous to `clk`.
- `uart_en`  out  1  one-cycle pulse: word valid.
- `uart_sel`  out  2  target: 2'd1 = data memory, 2'd2 = instruction load.
- `uart_data`  out  16  assembled word, `{hi, lo}`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `hdr_err`  out  1  one-cycle pulse: unknown header byte.
- `busy`  out  1  high while a packet is partially received.

## Operation
- **Input sync:** `rx` passes through a 2-flop synchronizer; both flops reset to 1.
- **Byte receiver FSM** (RX_IDLE, RX_START, RX_DATA, RX_STOP), with bit counter (0..CLKS_PER_BIT-1) and 3-bit index:
  - RX_IDLE: synced rx low → RX_START, counter cleared.
  - RX_START: at count CLKS_PER_BIT/2-1, sample. Low → RX_DATA. High → RX_IDLE (glitch, no error).
  - RX_DATA: 8 samples, one every CLKS_PER_BIT cycles, LSB first.
  - RX_STOP: sample one bit period later. High → `byte_valid` pulse. Low → `frame_err` pulse, byte discarded. Either way → RX_IDLE the next cycle.
- **Packet FSM** (P_HDR, P_HI, P_LO):
  - P_HDR: byte 0x01 → sel=1, P_HI. Byte 0x02 → sel=2, P_HI. Other → `hdr_err` pulse, stay in P_HDR.
  - P_HI: latch high byte → P_LO.
  - P_LO: on byte, register `uart_data={hi,byte}` and `uart_sel`, pulse `uart_en` → P_HDR.
  - `frame_err` in P_HI/P_LO: abort to P_HDR, no `uart_en`.
  - Timeout: idle counter clears on every `byte_valid`. Reaching TIMEOUT_BITS*CLKS_PER_BIT cycles in P_HI/P_LO → P_HDR silently.
- `busy` = packet state ≠ P_HDR.
- `uart_sel`/`uart_data` hold their last values between pulses.

## Timing
- Reset values: `uart_en`=0, `uart_sel`=0, `uart_data`=0, `frame_err`=0, `hdr_err`=0, `busy`=0. Both FSMs return to idle states and all counters clear.
- Let t0 be the first cycle synced rx is low. Stop sample and `byte_valid`/`frame_err` occur at t0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT.
- `uart_en` asserts one cycle after the low byte's `byte_valid`; `hdr_err` likewise one cycle after its byte.
- Pulses never exceed one cycle.
- Minimum spacing between `uart_en` pulses is 30 bit periods.
- A new start bit is accepted the cycle after RX_STOP exits, so back-to-back bytes with a 1-bit stop lose nothing.
- Reset mid-byte or mid-packet: partial data is dropped and no pulse is emitted.
- Timeout coinciding with `byte_valid`: the byte wins and the timeout counter clears.

## Structure
- Package `uart_loader_pkg` holds:
  - HDR_MEM=8'h01, HDR_INST=8'h02
  - SEL_MEM=2'd1, SEL_INST=2'd2
  - rx-state and packet-state enums
- Sub-module `uart_rx_byte` contains the synchronizer, the byte FSM, and the `byte_valid`/`byte_data`/`frame_err` outputs. The top level holds the packet FSM and timeout logic.

## Test plan
Use CLKS_PER_BIT=16, TIMEOUT_BITS=32.
1. Send 0x02, 0x12, 0x34 → exactly one `uart_en` pulse with `uart_sel`=2, `uart_data`=0x1234, at the stated latency; `busy` low afterward.
2. Send 0x01, 0xAB, 0xCD back-to-back with 1 stop bit → `uart_sel`=1, `uart_data`=0xABCD; values hold until the next packet.
3. Send 0x07 → one `hdr_err` pulse, no `uart_en`. Then 0x02, 0x00, 0x01 → `uart_data`=0x0001, `uart_sel`=2.
4. Send 0x01, then 0x55 with stop bit low → `frame_err` pulse, `busy` drops, no `uart_en`. Then 0x01, 0x00, 0x02 → `uart_data`=0x0002.
5. Send 0x02, 0x55, then idle 40 bit periods → `busy` falls at exactly 32 bit periods after 0x55's `byte_valid`. Then 0x02, 0xBE, 0xEF → `uart_data`=0xBEEF.
6. Drive a 4-cycle low glitch on `rx` → no `byte_valid` and no error. Assert `reset` mid-way through a data byte → all outputs 0; the next full packet is received correctly.

Source files
------------

// File: rtl/uart_loader_pkg.sv
// Shared constants, state encodings and header decode for the UART word loader.
package uart_loader_pkg;

  localparam logic [7:0] HDR_MEM  = 8'h01;
  localparam logic [7:0] HDR_INST = 8'h02;

  localparam logic [1:0] SEL_MEM  = 2'd1;
  localparam logic [1:0] SEL_INST = 2'd2;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  typedef enum logic [1:0] {
    PHdr,
    PHi,
    PLo
  } pkt_state_e;

  // Unknown headers map to 2'd0, which is never a legal target select.
  function automatic logic [1:0] hdr_to_sel(input logic [7:0] hdr);
    case (hdr)
      HDR_MEM:  return SEL_MEM;
      HDR_INST: return SEL_INST;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop rx synchronizer, mid-bit sampling FSM, one-cycle
// byte_valid / frame_err strobes issued in the stop-bit sample cycle.
module uart_rx_byte
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta_q, rx_sync_q;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      state_q   <= RxIdle;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx_i;
      rx_sync_q <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (!rx_sync_q) begin
          state_d = RxStart;
          cnt_d   = '0;
        end
      end
      RxStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is high again at mid-bit was a glitch.
          state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
            state_d = RxStop;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_q == CntLast) begin
          cnt_d        = '0;
          state_d      = RxIdle;
          byte_valid_o = rx_sync_q;
          frame_err_o  = ~rx_sync_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign byte_data_o = shift_q;

endmodule

// File: rtl/uart_word_loader.sv
// Assembles {header, hi, lo} UART packets into 16-bit load words for the CPU
// instruction/data load ports, with header checking and a mid-packet timeout.
module uart_word_loader
  import uart_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        uart_en,
  output logic [1:0]  uart_sel,
  output logic [15:0] uart_data,
  output logic        frame_err,
  output logic        hdr_err,
  output logic        busy
);

  localparam int unsigned TimeoutCycles = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned IdleW = $clog2(TimeoutCycles + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TimeoutCycles - 1);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       rx_frame_err;
  logic [1:0] hdr_sel;

  pkt_state_e       state_q, state_d;
  logic [1:0]       sel_hdr_q, sel_hdr_d;
  logic [7:0]       hi_q, hi_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic             uart_en_q, uart_en_d;
  logic             hdr_err_q, hdr_err_d;
  logic [1:0]       uart_sel_q, uart_sel_d;
  logic [15:0]      uart_data_q, uart_data_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i       (clk),
    .rst_i       (reset),
    .rx_i        (rx),
    .byte_valid_o(byte_valid),
    .byte_data_o (byte_data),
    .frame_err_o (rx_frame_err)
  );

  assign hdr_sel = hdr_to_sel(byte_data);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= PHdr;
      sel_hdr_q   <= '0;
      hi_q        <= '0;
      idle_q      <= '0;
      uart_en_q   <= 1'b0;
      hdr_err_q   <= 1'b0;
      uart_sel_q  <= '0;
      uart_data_q <= '0;
    end else begin
      state_q     <= state_d;
      sel_hdr_q   <= sel_hdr_d;
      hi_q        <= hi_d;
      idle_q      <= idle_d;
      uart_en_q   <= uart_en_d;
      hdr_err_q   <= hdr_err_d;
      uart_sel_q  <= uart_sel_d;
      uart_data_q <= uart_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_hdr_d   = sel_hdr_q;
    hi_d        = hi_q;
    idle_d      = idle_q;
    uart_en_d   = 1'b0;
    hdr_err_d   = 1'b0;
    uart_sel_d  = uart_sel_q;
    uart_data_d = uart_data_q;
    // A received byte outranks both the timeout and the idle count.
    if (byte_valid) begin
      idle_d = IdleW'(1);
      unique case (state_q)
        PHdr: begin
          if (hdr_sel == 2'd0) begin
            hdr_err_d = 1'b1;
          end else begin
            sel_hdr_d = hdr_sel;
            state_d   = PHi;
          end
        end
        PHi: begin
          hi_d    = byte_data;
          state_d = PLo;
        end
        PLo: begin
          uart_en_d   = 1'b1;
          uart_sel_d  = sel_hdr_q;
          uart_data_d = {hi_q, byte_data};
          state_d     = PHdr;
        end
        default: state_d = PHdr;
      endcase
    end else if (state_q != PHdr) begin
      if (rx_frame_err || idle_q == IdleLast) begin
        state_d = PHdr;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
    if (state_d == PHdr) begin
      idle_d = '0;
    end
  end

  assign uart_en   = uart_en_q;
  assign uart_sel  = uart_sel_q;
  assign uart_data = uart_data_q;
  assign hdr_err   = hdr_err_q;
  assign frame_err = rx_frame_err;
  assign busy      = (state_q != PHdr);

endmodule
